// File: rtl/nios_cmd_mailbox.sv
// Host-to-NIOS command byte queue: edge-detected host writes push, CPU acknowledge edges pop.
// Outputs are registered from queue state and lag the accepting edge by one clock; a full queue drops the push and sets a sticky overflow.
module nios_cmd_mailbox #(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] NOP_CODE = 8'h00
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     host_wr,
    input  logic [7:0]               host_data,
    input  logic                     cpu_ack,
    input  logic                     host_clr_ovf,
    output logic [7:0]               cmd_out,
    output logic                     cmd_pending,
    output logic                     host_busy,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          host_wr_q;
    logic          cpu_ack_q;
    logic          push_req;
    logic          pop_req;
    logic          push_acc;
    logic          pop_acc;

    // A pop frees a slot in the same cycle, so a full queue can still take a push alongside it.
    always_comb begin
        push_req = host_wr & ~host_wr_q;
        pop_req  = cpu_ack & ~cpu_ack_q;
        pop_acc  = pop_req && (count != '0);
        push_acc = push_req && ((count != FULL) || pop_acc);
    end

    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= host_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            host_wr_q <= 1'b0;
            cpu_ack_q <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
        end else begin
            host_wr_q <= host_wr;
            cpu_ack_q <= cpu_ack;
            if (push_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_acc, pop_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A dropped push outranks a clear arriving on the same edge.
            if (push_req && !push_acc) begin
                overflow <= 1'b1;
            end else if (host_clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_out     <= NOP_CODE;
            cmd_pending <= 1'b0;
            host_busy   <= 1'b0;
            fifo_level  <= '0;
        end else begin
            cmd_out     <= (count != '0) ? mem[rd_ptr] : NOP_CODE;
            cmd_pending <= (count != '0);
            host_busy   <= (count == FULL);
            fifo_level  <= count;
        end
    end

endmodule
